i2c_slave_regfile: RTL

// Synthesizable I2C target (responder) at 7-bit address DEV_ID with a REG_NUM x 8 register file.

---
 rtl/i2c_slave_regfile.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target at a 7-bit address with an 8-bit register file.
// Writes go through a register pointer. Reads use a repeated START.
// Local logic gets a combinational read port and a one-clock write strobe.
module i2c_slave_regfile #(
  parameter logic [6:0]  DEV_ID  = 7'h1E,
  parameter int unsigned REG_NUM = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] rf_raddr,
  output logic [7:0] rf_rdata,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int unsigned IdxW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StDevAddr = 4'd1;
  localparam logic [3:0] StDevAck  = 4'd2;
  localparam logic [3:0] StRegAddr = 4'd3;
  localparam logic [3:0] StRegAck  = 4'd4;
  localparam logic [3:0] StWrData  = 4'd5;
  localparam logic [3:0] StWrAck   = 4'd6;
  localparam logic [3:0] StRdData  = 4'd7;
  localparam logic [3:0] StRdAck   = 4'd8;
  localparam logic [3:0] StIgnore  = 4'd9;

  logic       scl_s1_q, scl_s2_q, scl_q;
  logic       sda_s1_q, sda_s2_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       commit;

  logic [7:0] regs_q [REG_NUM];
  logic [7:0] ptr_inc;
  logic       ptr_in_range, inc_in_range;
  logic [7:0] rd_cur, rd_next;

  // Two-flop synchronizers plus a third stage for edge detection.
  // Reset high so an idle bus is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_q    <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_q    <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_q    <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_q;
  assign scl_fall  = ~scl_s2_q & scl_q;
  assign start_det = scl_s2_q & scl_q & sda_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_q & ~sda_q & sda_s2_q;

  assign ptr_inc      = ptr_q + 8'd1;
  assign ptr_in_range = {24'd0, ptr_q} < REG_NUM;
  assign inc_in_range = {24'd0, ptr_inc} < REG_NUM;

  // Byte at the pointer and at the pointer plus one. Out-of-range reads return zero.
  always_comb begin
    rd_cur  = 8'h00;
    rd_next = 8'h00;
    if (ptr_in_range) rd_cur = regs_q[ptr_q[IdxW-1:0]];
    if (inc_in_range) rd_next = regs_q[ptr_inc[IdxW-1:0]];
  end

  // Protocol FSM next state. START and STOP take priority in every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    commit   = 1'b0;
    if (start_det) begin
      state_d  = StDevAddr;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        StDevAddr, StRegAddr, StWrData: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shreg_d = {shreg_q[6:0], sda_s2_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b1;
            if (state_q == StDevAddr) begin
              if (shreg_q[7:1] == DEV_ID) begin
                rw_d    = shreg_q[0];
                state_d = StDevAck;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = StIgnore;
              end
            end else if (state_q == StRegAddr) begin
              ptr_d   = shreg_q;
              state_d = StRegAck;
            end else begin
              state_d = StWrAck;
            end
          end
        end
        StDevAck: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              shreg_d  = rd_cur;
              sda_oe_d = ~rd_cur[7];
              state_d  = StRdData;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StRegAddr;
            end
          end
        end
        StRegAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = StWrData;
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            commit   = 1'b1;
            ptr_d    = ptr_inc;
            cnt_d    = 4'd0;
            state_d  = StWrData;
          end
        end
        StRdData: begin
          // cnt counts bits the host has sampled. Bit 7 is already driven on entry.
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = StRdAck;
          end else if (scl_fall && cnt_q != 4'd0) begin
            sda_oe_d = ~shreg_q[6];
            shreg_d  = {shreg_q[6:0], 1'b0};
          end
        end
        StRdAck: begin
          // cnt == 1 marks that the host ACKed and wants another byte.
          if (scl_rise) begin
            if (sda_s2_q) begin
              ptr_d   = ptr_inc;
              state_d = StIgnore;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            ptr_d    = ptr_inc;
            shreg_d  = rd_next;
            sda_oe_d = ~rd_next[7];
            cnt_d    = 4'd0;
            state_d  = StRdData;
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state registers. The SDA driver clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      shreg_q  <= 8'h00;
      ptr_q    <= 8'h00;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  // Register file commit and write strobe. Out-of-range writes are dropped silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_NUM); i++) regs_q[i] <= 8'h00;
      wr_pulse <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
    end else begin
      wr_pulse <= 1'b0;
      if (commit && ptr_in_range) begin
        regs_q[ptr_q[IdxW-1:0]] <= shreg_q;
        wr_pulse <= 1'b1;
        wr_addr  <= ptr_q;
        wr_data  <= shreg_q;
      end
    end
  end

  // Local read port.
  always_comb begin
    rf_rdata = 8'h00;
    if ({24'd0, rf_raddr} < REG_NUM) rf_rdata = regs_q[rf_raddr[IdxW-1:0]];
  end

  assign sda_oe = sda_oe_q;
  assign busy   = (state_q != StIdle);

endmodule
